// File: rtl/addr_calc.sv
// Per-sprite pixel hit test and sprite-memory address generator.
// One registered result per clock; output is zero whenever the pixel misses.
module addr_calc (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] pattern_info,
  input  logic [31:0] sprite_info,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_output,
  output logic        valid
);

  logic [15:0] base, width, height, stride;
  logic        visible, hflip;
  logic [9:0]  x_left, y_top;

  logic [16:0] hc_ext, vc_ext, x_ext, y_ext, x_end, y_end;
  logic [15:0] col, row, col_sel, row_off;
  logic        hit_d;
  logic [15:0] addr_d;
  logic        valid_q;
  logic [15:0] addr_q;
  logic        unused_fields;

  always_comb begin
    base    = pattern_info[79:64];
    width   = pattern_info[63:48];
    height  = pattern_info[47:32];
    stride  = pattern_info[31:16];
    visible = sprite_info[31];
    hflip   = sprite_info[30];
    y_top   = sprite_info[29:20];
    x_left  = sprite_info[19:10];
    unused_fields = ^{pattern_info[15:0], sprite_info[9:0]};
  end

  // 17-bit compare so x+W / y+H never wrap; nothing past column/row 1023 can hit.
  always_comb begin
    hc_ext = {7'b0, hcount};
    vc_ext = {7'b0, vcount};
    x_ext  = {7'b0, x_left};
    y_ext  = {7'b0, y_top};
    x_end  = x_ext + {1'b0, width};
    y_end  = y_ext + {1'b0, height};
    hit_d  = visible && (hc_ext >= x_ext) && (hc_ext < x_end)
                     && (vc_ext >= y_ext) && (vc_ext < y_end);
  end

  always_comb begin
    col     = {6'b0, hcount} - {6'b0, x_left};
    row     = {6'b0, vcount} - {6'b0, y_top};
    col_sel = hflip ? (width - 16'd1 - col) : col;
    row_off = row * stride;
    addr_d  = '0;
    if (hit_d) begin
      addr_d = base + row_off + col_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= hit_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    valid       = valid_q;
    addr_output = addr_q;
  end

endmodule

// File: tb/tb_addr_calc.sv
// Bench for addr_calc: vector table plus streaming scoreboard, reset and
// screen-edge sequences, and randomized model-checked traffic.
module tb_addr_calc;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  addr_calc dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [79:0] pat;
    logic [31:0] spr;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        ev;
    logic [15:0] ea;
  } vec_t;

  typedef struct {
    string       name;
    logic        ev;
    logic [15:0] ea;
  } exp_t;

  exp_t sb[$];
  int unsigned nvec = 0;
  int unsigned nmis = 0;

  localparam logic [79:0] PAT = {16'd128, 16'd8, 16'd16, 16'd8, 16'd0};
  localparam logic [31:0] SPR = 32'h83219000;
  localparam logic [31:0] SPR_FLIP = 32'hC3219000;
  localparam logic [31:0] SPR_HIDE = 32'h03219000;
  localparam logic [31:0] SPR_EDGE = 32'h832FF000;

  task automatic check(input string name, input logic ev, input logic [15:0] ea);
    nvec++;
    if (valid !== ev || addr_output !== ea) begin
      nmis++;
      $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
               name, valid, addr_output, ev, ea);
    end
  endtask

  // Independent reference: plain integer arithmetic on the field layout.
  function automatic void model(input logic [79:0] p, input logic [31:0] s,
                                input logic [9:0] h, input logic [9:0] v,
                                output logic ev, output logic [15:0] ea);
    int unsigned x, y, w, hh, st, b, c;
    x  = s[19:10];
    y  = s[29:20];
    b  = p[79:64];
    w  = p[63:48];
    hh = p[47:32];
    st = p[31:16];
    ev = s[31] && (h >= x) && (h < x + w) && (v >= y) && (v < y + hh);
    ea = '0;
    if (ev) begin
      c = h - x;
      if (s[30]) c = w - 1 - c;
      ea = 16'(b + (v - y) * st + c);
    end
  endfunction

  task automatic drive(input string name, input logic [79:0] p, input logic [31:0] s,
                       input logic [9:0] h, input logic [9:0] v,
                       input logic ev, input logic [15:0] ea);
    exp_t e;
    @(negedge clk);
    pattern_info = p;
    sprite_info  = s;
    hcount       = h;
    vcount       = v;
    e.name = name;
    e.ev   = ev;
    e.ea   = ea;
    sb.push_back(e);
  endtask

  // Each expectation is consumed just after the edge that registers it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, e.ev, e.ea);
    end
  end

  task automatic drain();
    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic        ev;
    logic [15:0] ea;
    logic [79:0] rp;
    logic [31:0] rs;
    logic [9:0]  rh, rv;
    int unsigned rx, ry, rw, rhh;

    tbl.push_back('{"top_left",     PAT, SPR,      10'd100, 10'd50, 1'b1, 16'd128});
    tbl.push_back('{"bottom_right", PAT, SPR,      10'd107, 10'd65, 1'b1, 16'd255});
    tbl.push_back('{"past_right",   PAT, SPR,      10'd108, 10'd50, 1'b0, 16'd0});
    tbl.push_back('{"before_left",  PAT, SPR,      10'd99,  10'd50, 1'b0, 16'd0});
    tbl.push_back('{"past_bottom",  PAT, SPR,      10'd100, 10'd66, 1'b0, 16'd0});
    tbl.push_back('{"above_top",    PAT, SPR,      10'd100, 10'd49, 1'b0, 16'd0});
    tbl.push_back('{"flip_left",    PAT, SPR_FLIP, 10'd100, 10'd50, 1'b1, 16'd135});
    tbl.push_back('{"flip_right",   PAT, SPR_FLIP, 10'd107, 10'd50, 1'b1, 16'd128});
    tbl.push_back('{"flip_mid",     PAT, SPR_FLIP, 10'd102, 10'd51, 1'b1, 16'd141});
    tbl.push_back('{"hidden",       PAT, SPR_HIDE, 10'd100, 10'd50, 1'b0, 16'd0});
    tbl.push_back('{"zero_width",   {16'd128, 16'd0, 16'd16, 16'd8, 16'd0}, SPR,
                    10'd100, 10'd50, 1'b0, 16'd0});
    tbl.push_back('{"zero_height",  {16'd128, 16'd8, 16'd0, 16'd8, 16'd0}, SPR,
                    10'd100, 10'd50, 1'b0, 16'd0});
    tbl.push_back('{"addr_wrap",    {16'hFFF0, 16'd8, 16'd16, 16'd8, 16'hBEEF}, SPR,
                    10'd107, 10'd65, 1'b1, 16'h006F});
    tbl.push_back('{"edge_1023",    PAT, SPR_EDGE, 10'd1023, 10'd50, 1'b1, 16'd131});
    tbl.push_back('{"edge_h0",      PAT, SPR_EDGE, 10'd0,    10'd50, 1'b0, 16'd0});
    tbl.push_back('{"edge_h1",      PAT, SPR_EDGE, 10'd1,    10'd50, 1'b0, 16'd0});
    tbl.push_back('{"edge_h2",      PAT, SPR_EDGE, 10'd2,    10'd50, 1'b0, 16'd0});
    tbl.push_back('{"edge_h3",      PAT, SPR_EDGE, 10'd3,    10'd50, 1'b0, 16'd0});
    tbl.push_back('{"edge_flip",    PAT, SPR_EDGE | 32'h40000000, 10'd1023, 10'd50,
                    1'b1, 16'd132});

    reset        = 1'b0;
    pattern_info = PAT;
    sprite_info  = SPR;
    hcount       = 10'd100;
    vcount       = 10'd50;
    #2;
    check("reset_state", 1'b0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) drive(tbl[i].name, tbl[i].pat, tbl[i].spr, tbl[i].h, tbl[i].v,
                          tbl[i].ev, tbl[i].ea);
    drain();

    for (int unsigned i = 0; i < 8; i++)
      drive("toggle_vis", PAT, (i % 2 == 0) ? SPR : SPR_HIDE, 10'd100, 10'd50,
            (i % 2 == 0), (i % 2 == 0) ? 16'd128 : 16'd0);
    drain();

    for (int unsigned i = 0; i < 60; i++) begin
      rx  = $urandom_range(1023);
      ry  = $urandom_range(1023);
      rw  = $urandom_range(12);
      rhh = $urandom_range(12);
      rp  = {16'($urandom), 16'(rw), 16'(rhh), 16'($urandom_range(300)), 16'($urandom)};
      rs  = {1'($urandom_range(3) != 0), 1'($urandom), 10'(ry), 10'(rx), 10'($urandom)};
      rh  = 10'(rx + $urandom_range(rw + 1) - 1);
      rv  = 10'(ry + $urandom_range(rhh + 1) - 1);
      model(rp, rs, rh, rv, ev, ea);
      drive("random", rp, rs, rh, rv, ev, ea);
    end
    drain();

    drive("pre_reset_hit", PAT, SPR, 10'd101, 10'd52, 1'b1, 16'd145);
    drain();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", 1'b0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_inputs_hit", 1'b0, 16'd0);
    drive("first_after_reset", PAT, SPR, 10'd103, 10'd60, 1'b1, 16'd211);
    reset = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
